alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer and arbiter that shares the single combinational 32-bit ALU between two requesters, e.g. the execute stage and the multdiv unit. It grants one operation at a time using round-robin priority and drives the latched opcode, shift amount and operands onto the ALU. It holds them for a configurable settle time, captures result and flags into registers, and returns them to the winning requester with a one-cycle response pulse.

## Interface
- WIDTH, 32, operand/result width; must match the ALU (fixed 32).
- ALU_LAT, 1, cycles operands are held on the ALU before capture; legal 1..4.

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid && ready.
- req0_opcode / req1_opcode  in  5  ALU opcode: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra.
- req0_shamt / req1_shamt  in  5  shift amount.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse to requester 0/1.
- rsp_result  out  WIDTH  captured ALU result; shared by both requesters.
- rsp_ne, rsp_lt, rsp_ovf  out  1  captured isNotEqual, isLessThan, overflow.
- alu_opcode, alu_shamt  out  5  to ALU.
- alu_a, alu_b  out  WIDTH  to ALU.
- alu_result  in  WIDTH  from ALU.
- alu_ne, alu_lt, alu_ovf  in  1  from ALU.
- busy  out  1  high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - Exactly one ready is asserted, combinationally, for the grant winner when any valid is high.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester named by the priority pointer `prio`.
  - On handshake, the winner's opcode, shamt, a and b are latched into operand registers. The grant id is also latched, and the FSM moves to EXEC with `cnt = ALU_LAT-1`.
- **EXEC:**
  - alu_* outputs come from the operand registers in every state.
  - Each cycle, `cnt` decrements. When `cnt == 0`, alu_result and the three flags are captured into the rsp_* registers, and the FSM moves to RESP.
- **RESP:**
  - rsp<id>_valid is high for exactly one cycle; there is no backpressure.
  - `prio` is set to the other requester, and the FSM returns to IDLE.
- Both ready outputs are low in EXEC and RESP. A requester must hold valid and payload stable until ready.
- rsp_* registers hold their values until the next capture.
- The opcode is not decoded. Flags are captured verbatim; their meaning for non-sub opcodes is the ALU's.
- Opcodes outside the supported set are passed to the ALU unchanged.

## Timing
- **Reset values:** state IDLE, `prio`=0 (req0 preferred), operand registers 0. All alu_* outputs 0, all rsp_* outputs 0, busy 0, both ready 0 unless a valid is high in IDLE.
- **Latency:** handshake at edge T; EXEC occupies cycles T+1..T+ALU_LAT; capture at the edge ending T+ALU_LAT; rsp valid during cycle T+ALU_LAT+1.
- **Throughput:** back-to-back requests are accepted every ALU_LAT+2 cycles. The earliest next ready is the cycle after RESP.
- **Simultaneous valid:** grants alternate 0,1,0,1…. A continuously valid requester is never starved for more than one operation.
- **Valid dropped before ready:** no grant and no state change.
- **reset_n asserted mid-EXEC or mid-RESP:** the operation is discarded, no rsp pulse is emitted, and all outputs take their reset values immediately (asynchronous).
- **Release:** first grant on the first rising edge after reset_n deasserts.

## Test plan
- **Reset mid-op:** req0 add A=5, B=3 accepted, reset_n pulled low during EXEC → rsp0_valid never pulses; rsp_result=0, busy=0 immediately; after release, req0 add 1+1 → rsp_result 00000002.
- **Single request:** ALU_LAT=1, req0 add A=00000001, B=00000001 → req0_ready at T, rsp0_valid only at T+2, rsp_result=00000002, rsp_ovf=0, busy high T+1..T+2.
- **Contention:** req0 and req1 valid from reset; req0 sub 80000000−0F000000, req1 or 0000FFFF|FFFF0000 → req0 served first with rsp_ovf=1; then req1 with rsp_result=FFFFFFFF, rsp1_valid only.
- **Round-robin fairness:** both valid continuously for 6 ops → grant order 0,1,0,1,0,1; no ready while busy.
- **Latency parameter:** ALU_LAT=3, req1 sll A=00000001, shamt=00011 → rsp1_valid at T+4, rsp_result=00000008; alu_a stable T+1..T+3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Latches the granted operation, holds it on the ALU for ALU_LAT cycles, then captures and returns the result.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_opcode,
  input  logic [4:0]       req0_shamt,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_opcode,
  input  logic [4:0]       req1_shamt,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ne,
  output logic             rsp_lt,
  output logic             rsp_ovf,
  output logic [4:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ne,
  input  logic             alu_lt,
  input  logic             alu_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

  state_t           state_r, next_state_s;
  logic [1:0]       cnt_r;
  logic             prio_r;
  logic             gid_r;
  logic             grant_s;
  logic             hs_s;
  logic             capture_s;
  logic [4:0]       op_r, sh_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] res_r;
  logic             ne_r, lt_r, ovf_r;
  logic             rsp0_r, rsp1_r, busy_r;

  // Next-state, grant and combinational ready generation.
  always_comb begin
    next_state_s = state_r;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    hs_s         = 1'b0;
    capture_s    = 1'b0;
    // grant_s = 1 selects req1; prio_r breaks a tie only when both are valid
    grant_s      = req1_valid & (~req0_valid | prio_r);
    case (state_r)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant_s;
          req1_ready   = grant_s;
          hs_s         = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 2'd0) begin
          capture_s    = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = EXEC;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Control state: FSM, settle counter, priority pointer, grant id and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      prio_r  <= 1'b0;
      gid_r   <= 1'b0;
      rsp0_r  <= 1'b0;
      rsp1_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      rsp0_r  <= capture_s & ~gid_r;
      rsp1_r  <= capture_s & gid_r;
      busy_r  <= (next_state_s != IDLE);
      if (hs_s) begin
        cnt_r <= CNT_INIT;
        gid_r <= grant_s;
      end else if (state_r == EXEC && cnt_r != 2'd0) begin
        cnt_r <= cnt_r - 2'd1;
      end
      if (state_r == RESP) begin
        prio_r <= ~gid_r;
      end
    end
  end

  // Operand latch on handshake and result/flag capture at the end of the settle window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r  <= 5'd0;
      sh_r  <= 5'd0;
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      res_r <= {WIDTH{1'b0}};
      ne_r  <= 1'b0;
      lt_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (hs_s) begin
        op_r <= grant_s ? req1_opcode : req0_opcode;
        sh_r <= grant_s ? req1_shamt  : req0_shamt;
        a_r  <= grant_s ? req1_a      : req0_a;
        b_r  <= grant_s ? req1_b      : req0_b;
      end
      if (capture_s) begin
        res_r <= alu_result;
        ne_r  <= alu_ne;
        lt_r  <= alu_lt;
        ovf_r <= alu_ovf;
      end
    end
  end

  assign alu_opcode = op_r;
  assign alu_shamt  = sh_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign rsp_result = res_r;
  assign rsp_ne     = ne_r;
  assign rsp_lt     = lt_r;
  assign rsp_ovf    = ovf_r;
  assign rsp0_valid = rsp0_r;
  assign rsp1_valid = rsp1_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (ALU_LAT 1 and 3) with a behavioural ALU,
// checked cycle by cycle against a queue-based round-robin/latency reference model.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  localparam int LAT_TAB [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rv   [2][2];
  logic        rr   [2][2];
  logic [4:0]  rop  [2][2];
  logic [4:0]  rsh  [2][2];
  logic [31:0] ra   [2][2];
  logic [31:0] rb   [2][2];
  logic        rspv [2][2];
  logic [31:0] rsp_res [2];
  logic        rsp_ne [2], rsp_lt [2], rsp_ovf [2];
  logic [4:0]  aop [2], ash [2];
  logic [31:0] aa [2], ab [2];
  logic [31:0] ares [2];
  logic        ane [2], alt [2], aovf [2];
  logic        busy [2];

  always #5 clk = ~clk;

  // Reference ALU: {ovf, lt, ne, result}; unknown opcodes give a distinctive value
  function automatic logic [34:0] alu_f(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = $unsigned($signed(a) >>> sh);
      default: r = a ^ b ^ {27'd0, op};
    endcase
    return {ovf, ($signed(a) < $signed(b)), (a != b), r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {aovf[g], alt[g], ane[g], ares[g]} = alu_f(aop[g], ash[g], aa[g], ab[g]);
    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(LAT_TAB[g])) u_dut (
      .clock(clk), .reset_n(reset_n),
      .req0_valid(rv[g][0]), .req0_ready(rr[g][0]), .req0_opcode(rop[g][0]),
      .req0_shamt(rsh[g][0]), .req0_a(ra[g][0]), .req0_b(rb[g][0]),
      .req1_valid(rv[g][1]), .req1_ready(rr[g][1]), .req1_opcode(rop[g][1]),
      .req1_shamt(rsh[g][1]), .req1_a(ra[g][1]), .req1_b(rb[g][1]),
      .rsp0_valid(rspv[g][0]), .rsp1_valid(rspv[g][1]), .rsp_result(rsp_res[g]),
      .rsp_ne(rsp_ne[g]), .rsp_lt(rsp_lt[g]), .rsp_ovf(rsp_ovf[g]),
      .alu_opcode(aop[g]), .alu_shamt(ash[g]), .alu_a(aa[g]), .alu_b(ab[g]),
      .alu_result(ares[g]), .alu_ne(ane[g]), .alu_lt(alt[g]), .alu_ovf(aovf[g]),
      .busy(busy[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  op_t         q0[$], q1[$];
  bit          pres [2];
  op_t         cur [2];
  int          busy_left;
  int          gid;
  bit          prio;
  logic [34:0] exp_rsp, last_rsp;
  op_t         latched;
  int          grant_log[$];
  int          rsp_id_log[$];
  logic [34:0] rsp_log[$];

  function automatic op_t mk(input logic [4:0] op, input logic [4:0] sh,
                             input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.op = op; o.sh = sh; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    return mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), rand_word(), rand_word());
  endfunction

  task automatic model_reset();
    busy_left = 0; gid = 0; prio = 1'b0;
    last_rsp = 35'd0; exp_rsp = 35'd0; latched = '0;
    pres[0] = 1'b0; pres[1] = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model past the posedge
  task automatic step(input int u, input int mode);
    int win;
    logic [34:0] exp_regs;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      if (!pres[r]) begin
        if (r == 0 && q0.size() > 0 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
          cur[0] = q0.pop_front(); pres[0] = 1'b1;
        end else if (r == 1 && q1.size() > 0 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
          cur[1] = q1.pop_front(); pres[1] = 1'b1;
        end
      end else if (busy_left > 0 && mode == 0 && $urandom_range(0, 7) == 0) begin
        if (r == 0) q0.push_front(cur[0]); else q1.push_front(cur[1]);
        pres[r] = 1'b0;
      end
      rv[u][r] = pres[r];
      rop[u][r] = cur[r].op; rsh[u][r] = cur[r].sh; ra[u][r] = cur[r].a; rb[u][r] = cur[r].b;
    end
    #1;
    win = -1;
    if (busy_left == 0) begin
      if (pres[0] && pres[1]) win = prio ? 1 : 0;
      else if (pres[0])       win = 0;
      else if (pres[1])       win = 1;
    end
    exp_regs = (busy_left == 1) ? exp_rsp : last_rsp;
    check("ready0", rr[u][0], (win == 0));
    check("ready1", rr[u][1], (win == 1));
    check("busy", busy[u], (busy_left > 0));
    check("rsp0_valid", rspv[u][0], (busy_left == 1 && gid == 0));
    check("rsp1_valid", rspv[u][1], (busy_left == 1 && gid == 1));
    check("rsp_regs", {rsp_ovf[u], rsp_lt[u], rsp_ne[u], rsp_res[u]}, exp_regs);
    check("alu_ab", {aa[u], ab[u]}, {latched.a, latched.b});
    check("alu_op_sh", {aop[u], ash[u]}, {latched.op, latched.sh});
    if (rspv[u][0] || rspv[u][1]) begin
      rsp_log.push_back({rsp_ovf[u], rsp_lt[u], rsp_ne[u], rsp_res[u]});
      rsp_id_log.push_back(rspv[u][1] ? 1 : 0);
    end
    if (busy_left == 1) begin
      last_rsp = exp_rsp; prio = (gid == 0); busy_left = 0;
    end else if (busy_left > 1) begin
      busy_left--;
    end else if (win >= 0) begin
      gid = win; latched = cur[win];
      exp_rsp = alu_f(latched.op, latched.sh, latched.a, latched.b);
      pres[win] = 1'b0; busy_left = LAT_TAB[u] + 1;
      grant_log.push_back(win);
    end
  endtask

  task automatic run(input int u, input int mode, input int max_cycles);
    int c;
    c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pres[0] || pres[1] || busy_left != 0) && c < max_cycles) begin
      step(u, mode);
      c++;
    end
    check("run_complete", (c < max_cycles), 1'b1);
  endtask

  initial begin
    int gb, rbase;
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++)
      for (int r = 0; r < 2; r++) begin
        rv[u][r] = 1'b0; rop[u][r] = 5'd0; rsh[u][r] = 5'd0; ra[u][r] = 32'd0; rb[u][r] = 32'd0;
      end
    model_reset();
    #12;
    for (int u = 0; u < 2; u++) begin
      check("reset_busy", busy[u], 1'b0);
      check("reset_ready", {rr[u][0], rr[u][1]}, 2'b00);
      check("reset_rsp", {rspv[u][0], rspv[u][1], rsp_res[u], rsp_ovf[u]}, 35'd0);
      check("reset_alu", {aa[u], ab[u]}, 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Instance 0 (ALU_LAT=1): contention straight from reset
    gb = grant_log.size(); rbase = rsp_log.size();
    q0.push_back(mk(5'd1, 5'd0, 32'h8000_0000, 32'h0F00_0000));
    q1.push_back(mk(5'd3, 5'd0, 32'h0000_FFFF, 32'hFFFF_0000));
    run(0, 1, 40);
    check("cont_first_grant", grant_log[gb], 0);
    check("cont_second_grant", grant_log[gb + 1], 1);
    check("cont_sub_result", rsp_log[rbase][31:0], 32'h7100_0000);
    check("cont_sub_ovf", rsp_log[rbase][34], 1'b1);
    check("cont_or_result", rsp_log[rbase + 1][31:0], 32'hFFFF_FFFF);
    check("cont_or_id", rsp_id_log[rbase + 1], 1);

    // Round-robin fairness with both requesters continuously valid
    gb = grant_log.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run(0, 1, 80);
    for (int i = 0; i < 6; i++) check("rr_order", grant_log[gb + i], i % 2);

    // Single request add 1+1
    rbase = rsp_log.size();
    q0.push_back(mk(5'd0, 5'd0, 32'd1, 32'd1));
    run(0, 1, 20);
    check("single_result", rsp_log[rbase][31:0], 32'd2);
    check("single_ovf", rsp_log[rbase][34], 1'b0);

    // Random traffic with withdrawals and unsupported opcodes
    for (int i = 0; i < 25; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run(0, 0, 2000);

    // Instance 1 (ALU_LAT=3): starts from reset state
    model_reset();
    rbase = rsp_log.size();
    q1.push_back(mk(5'd4, 5'd3, 32'd1, 32'd0));
    run(1, 1, 30);
    check("sll_result", rsp_log[rbase][31:0], 32'd8);
    check("sll_id", rsp_id_log[rbase], 1);

    // Reset during EXEC discards the operation
    rbase = rsp_log.size();
    q0.push_back(mk(5'd0, 5'd0, 32'd5, 32'd3));
    for (int c = 0; c < 10 && busy_left == 0; c++) step(1, 1);
    check("rst_op_accepted", (busy_left > 0), 1'b1);
    @(negedge clk);
    rv[1][0] = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy[1], 1'b0);
    check("rst_result", rsp_res[1], 32'd0);
    check("rst_alu_a", aa[1], 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("rst_no_rsp", {rspv[1][0], rspv[1][1]}, 2'b00);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    q0.push_back(mk(5'd0, 5'd0, 32'd1, 32'd1));
    run(1, 1, 30);
    check("post_rst_count", rsp_log.size() - rbase, 1);
    check("post_rst_result", rsp_log[rsp_log.size() - 1][31:0], 32'd2);

    for (int i = 0; i < 20; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run(1, 0, 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
